fp_div: RTL and testbench
=========================

Name: fp_div

Overview:
- Pipelined-handshake IEEE-style floating-point divider for the vector/arithmetic datapath.
- Computes result = operand1 / operand2 with parameterized exponent and mantissa widths. Default format is BF16; FP16 is 5/10.
- One operation in flight at a time, using a valid/ready handshake on both input and output.
- Ports are grouped in interface div_if, which holds an input bundle "in" and an output bundle "out".

Parameters:
- EXP_WIDTH, 8, exponent field width (FP16: 5).
- MANT_WIDTH, 7, stored mantissa width (FP16: 10).
- WIDTH, EXP_WIDTH+MANT_WIDTH+1, derived operand/result width (not overridable).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- divif.in.operand1  in  WIDTH  dividend {sign, exp, mant}.
- divif.in.operand2  in  WIDTH  divisor.
- divif.in.valid_in  in  1  input request valid.
- divif.in.ready_out  in  1  downstream accepts result.
- divif.out.ready_in  out  1  block can accept an operation.
- divif.out.valid_out  out  1  result valid.
- divif.out.result  out  WIDTH  quotient.

Behaviour:
- Reset (async, nRST=0): ready_in=0, valid_out=0, result=0, state=IDLE.
- First rising edge after nRST deasserts: ready_in=1.
- States:
  - IDLE (ready_in=1): on the edge where valid_in & ready_in, latch both operands and go to BUSY; ready_in=0 from the next cycle.
  - BUSY: radix-2 restoring mantissa division, one quotient bit per cycle. Produces MANT_WIDTH+3 quotient bits (guard, round, sticky from remainder!=0). Fixed latency MANT_WIDTH+4 cycles from accept to valid_out=1. Special cases may finish in the same fixed latency.
  - DONE: valid_out=1, result stable, ready_in=0. Hold until ready_out=1 at a rising edge; then valid_out=0 and ready_in=1 on the following cycle (back to IDLE).
- valid_in while not in IDLE is ignored. Operand changes after acceptance do not affect the in-flight result.
- Reset mid-operation aborts immediately to the reset values.
- Sign: sign1 XOR sign2, for all non-NaN results including zeros and infinities.
- Flush-to-zero: subnormal inputs (exp=0, mant!=0) are treated as signed zero. Subnormal or underflowing results become signed zero.
- Special cases, checked in this priority order:
  - Any NaN input, 0/0, or inf/inf -> canonical qNaN: sign 0, exp all ones, mant MSB 1, rest 0 (BF16 0x7FC0). sNaN inputs also give the canonical qNaN.
  - inf/x (x finite or zero) -> signed inf.
  - x/0 (x finite nonzero) -> signed inf.
  - 0/x and x/inf -> signed zero.
- Normal path:
  - exp = e1 - e2 + bias, bias = 2^(EXP_WIDTH-1)-1. Compute in signed arithmetic at least EXP_WIDTH+2 bits wide.
  - Mantissas carry the hidden 1. If quotient mantissa < 1, shift left 1 and decrement exp.
  - Round to nearest, ties to even. A rounding carry out renormalises and increments exp.
- Exponent limits:
  - Final exp >= all-ones -> signed inf.
  - Final exp <= 0 -> signed zero.

Test Plan:
- Reset: while nRST=0, at a clock edge -> valid_out=0, ready_in=0. After release plus one edge -> ready_in=1.
- Basic handshake and normal values (BF16):
  - 0x3F80/0x3F80 -> 0x3F80.
  - 0x3F80/0x4000 -> 0x3F00.
  - 0x7F7F/0x7F7F -> 0x3F80.
  - 0x0080/0x3F80 -> 0x0080.
  - 0x7F7F/0x3F80 -> 0x7F7F.
  - ready_in must fall after accept; valid_out must hold until ready_out.
- Zero and infinity cases:
  - 0x3F80/0x0000 -> 0x7F80.
  - 0x0000/0x3F80 -> 0x0000.
  - 0x0000/0x0000 -> NaN.
  - 0x7F80/0x7F80 -> NaN.
  - 0x7F80/0x0000 -> 0x7F80.
  - 0x0000/0x7F80 -> 0x0000.
  - 0x3F80/0x7F80 -> 0x0000.
- NaN cases: 0x7FC0 with 1.0, inf, 0, or NaN, in either operand position -> 0x7FC0. sNaN 0x7FBF/0x3F80 -> 0x7FC0.
- Subnormal flush and underflow:
  - 0x0001/0x3F80 -> 0x0000.
  - 0x007F/0x3F80 -> 0x0000.
  - 0x0001/0x4000 -> 0x0000.
  - 0x3F80/0x7F7F -> 0x0000.
- Overflow:
  - 0x7F7F/0x0001 -> 0x7F80.
  - 0xFF7F/0x0001 -> 0xFF80.
- Backpressure: hold ready_out=0 for 5 cycles after valid_out rises -> result unchanged, no new accept. Then pulse ready_out -> valid_out=0, ready_in=1 on the next cycle.

Source files
------------

// File: rtl/fp_div_if.sv
// div_if: port bundle for fp_div.
//   in  : operand1, operand2 (dividend, divisor), valid_in, ready_out
//   out : ready_in, valid_out, result
// Field order inside each packed struct is fixed; fp_div drives "out" as a
// single concatenation in that order.
interface div_if #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7
);
  localparam int WIDTH = EXP_WIDTH + MANT_WIDTH + 1;

  typedef struct packed {
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             valid_in;
    logic             ready_out;
  } in_t;

  typedef struct packed {
    logic             ready_in;
    logic             valid_out;
    logic [WIDTH-1:0] result;
  } out_t;

  in_t  in;
  out_t out;

  modport dut (input in, output out);
  modport tb  (output in, input out);
endinterface

// File: rtl/fp_div.sv
// fp_div: floating-point divider, result = operand1 / operand2.
// One operation in flight. Valid/ready handshake on both sides.
// Radix-2 restoring mantissa division, one quotient bit per cycle.
// Fixed latency of MANT_WIDTH+4 cycles from accept to valid_out.
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset
//   divif - div_if.dut bundle (operands, handshakes, result)
// Subnormal inputs and results are flushed to signed zero.
// Rounding is to nearest, ties to even.
module fp_div #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 7
) (
  input logic CLK,
  input logic nRST,
  div_if.dut  divif
);
  localparam int WIDTH = EXP_WIDTH + MANT_WIDTH + 1;
  localparam int QBITS = MANT_WIDTH + 3;  // integer bit, MANT_WIDTH fraction, guard, round
  localparam int EW    = EXP_WIDTH + 2;   // signed exponent working width
  localparam int CW    = $clog2(QBITS + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_WIDTH) - 1);
  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, next;

  logic                  s1, s2;
  logic [EXP_WIDTH-1:0]  e1, e2;
  logic [MANT_WIDTH-1:0] m1, m2;
  assign {s1, e1, m1} = divif.in.operand1;
  assign {s2, e2, m2} = divif.in.operand2;

  // Operand classification, evaluated at accept time only.
  logic nan1, nan2, inf1, inf2, zero1, zero2, sgn;
  logic             spec_hit;
  logic [WIDTH-1:0] spec_res;

  always_comb begin
    nan1  = (e1 == '1) && (m1 != '0);
    nan2  = (e2 == '1) && (m2 != '0);
    inf1  = (e1 == '1) && (m1 == '0);
    inf2  = (e2 == '1) && (m2 == '0);
    zero1 = (e1 == '0);  // subnormals count as zero
    zero2 = (e2 == '0);
    sgn   = s1 ^ s2;
    spec_hit = 1'b1;
    spec_res = '0;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2))
      spec_res = QNAN;
    else if (inf1 || zero2)
      spec_res = {sgn, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    else if (zero1 || inf2)
      spec_res = {sgn, {(WIDTH-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  // Datapath state
  logic                 ready_r, valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [CW-1:0]        cnt;
  logic [MANT_WIDTH+1:0] rem;
  logic [MANT_WIDTH:0]  dvs;
  logic [QBITS-1:0]     quo;
  logic signed [EW-1:0] exp_r;
  logic                 sign_r, special_r;
  logic [WIDTH-1:0]     spec_r;

  logic accept, last;
  assign accept = (state == IDLE) && divif.in.valid_in && ready_r;
  assign last   = (cnt == CW'(QBITS));

  // One restoring step
  logic                  ge;
  logic [MANT_WIDTH+1:0] diff;
  assign ge   = rem >= {1'b0, dvs};
  assign diff = ge ? rem - {1'b0, dvs} : rem;

  // Normalise + round, consumed on the final BUSY cycle
  logic [QBITS-1:0]      norm;
  logic [MANT_WIDTH:0]   sig;
  logic [MANT_WIDTH+1:0] sum;
  logic                  guard, sticky, rnd_up;
  logic signed [EW-1:0]  exp_n, exp_f;
  logic [WIDTH-1:0]      rounded;

  always_comb begin
    // Quotient lies in (0.5, 2); below 1 costs one exponent step.
    norm   = quo[QBITS-1] ? quo : {quo[QBITS-2:0], 1'b0};
    exp_n  = quo[QBITS-1] ? exp_r : exp_r - EW'(1);
    sig    = norm[QBITS-1:2];
    guard  = norm[1];
    sticky = (quo[QBITS-1] & quo[0]) | (rem != '0);
    rnd_up = guard & (sticky | sig[0]);
    sum    = {1'b0, sig} + {{(MANT_WIDTH+1){1'b0}}, rnd_up};
    // A carry out leaves the fraction all zero, so only the exponent moves.
    exp_f  = exp_n + $signed({{(EW-1){1'b0}}, sum[MANT_WIDTH+1]});
    if (exp_f >= EMAX)
      rounded = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    else if (exp_f <= $signed(EW'(0)))
      rounded = {sign_r, {(WIDTH-1){1'b0}}};
    else
      rounded = {sign_r, exp_f[EXP_WIDTH-1:0], sum[MANT_WIDTH-1:0]};
  end

  // FSM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) next = BUSY;
      BUSY:    if (last) next = DONE;
      DONE:    if (divif.in.ready_out) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ready_r   <= 1'b0;
      valid_r   <= 1'b0;
      result_r  <= '0;
      cnt       <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      special_r <= 1'b0;
      spec_r    <= '0;
    end else begin
      ready_r <= (next == IDLE);
      valid_r <= (next == DONE);
      if (accept) begin
        rem       <= {1'b0, 1'b1, m1};
        dvs       <= {1'b1, m2};
        quo       <= '0;
        cnt       <= '0;
        exp_r     <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + BIAS;
        sign_r    <= sgn;
        special_r <= spec_hit;
        spec_r    <= spec_res;
      end else if (state == BUSY) begin
        if (last) begin
          result_r <= special_r ? spec_r : rounded;
        end else begin
          quo <= {quo[QBITS-2:0], ge};
          rem <= {diff[MANT_WIDTH:0], 1'b0};
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign divif.out = {ready_r, valid_r, result_r};

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div (BF16). Scoreboard queue filled by the
// driver, drained by an independent monitor on each output handshake.
module tb_fp_div;
  localparam int E    = 8;
  localparam int M    = 7;
  localparam int W    = E + M + 1;
  localparam int LAT  = M + 4;
  localparam int ALL  = (1 << E) - 1;
  localparam int BIAS = (1 << (E - 1)) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  div_if #(.EXP_WIDTH(E), .MANT_WIDTH(M)) dif();
  fp_div #(.EXP_WIDTH(E), .MANT_WIDTH(M)) dut (.CLK(clk), .nRST(rst_n), .divif(dif));

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           acc;
  } txn_t;
  txn_t sbq[$];

  bit bp_mode = 1'b0;
  bit bp_val  = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    chk++;
    if (act !== req) begin
      err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: real-valued quotient of the significands, rounded to nearest even.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int  ea = int'(a[W-2:M]);
    int  eb = int'(b[W-2:M]);
    int  ma = int'(a[M-1:0]);
    int  mb = int'(b[M-1:0]);
    bit  sg = a[W-1] ^ b[W-1];
    bit  na = (ea == ALL) && (ma != 0);
    bit  nb = (eb == ALL) && (mb != 0);
    bit  ia = (ea == ALL) && (ma == 0);
    bit  ib = (eb == ALL) && (mb == 0);
    bit  za = (ea == 0);
    bit  zb = (eb == 0);
    real v, sc, fr;
    longint k;
    int e;
    if (na || nb || (za && zb) || (ia && ib)) return {1'b0, E'(ALL), 1'b1, (M-1)'(0)};
    if (ia || zb) return {sg, E'(ALL), M'(0)};
    if (za || ib) return {sg, (W-1)'(0)};
    v = real'((1 << M) + ma) / real'((1 << M) + mb);
    e = ea - eb + BIAS;
    if (v < 1.0) begin
      v = v * 2.0;
      e--;
    end
    sc = v * real'(1 << M);
    k  = longint'($floor(sc));
    fr = sc - real'(k);
    if (fr > 0.5 || (fr == 0.5 && k[0])) k++;
    if (k == (longint'(1) << (M + 1))) begin
      k = k >>> 1;
      e++;
    end
    if (e >= ALL) return {sg, E'(ALL), M'(0)};
    if (e <= 0) return {sg, (W-1)'(0)};
    return {sg, E'(e), M'(k)};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [E-1:0] e;
    if ($urandom_range(0, 3) == 0) e = E'($urandom);
    else e = E'(BIAS - 20 + int'($urandom_range(0, 40)));
    return {1'($urandom), e, M'($urandom)};
  endfunction

  // Downstream ready: random unless the backpressure test takes over.
  initial begin
    dif.in.ready_out = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dif.in.ready_out = bp_mode ? bp_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor
  logic         prev_v = 1'b0;
  logic [W-1:0] prev_res = '0;
  always @(negedge clk) begin
    txn_t t;
    if (rst_n) begin
      if (dif.out.valid_out) begin
        check("ready_in_low_while_valid", W'(dif.out.ready_in), W'(0));
        if (!prev_v) begin
          if (sbq.size() == 0) begin
            chk++;
            err++;
            $display("FAIL unexpected_valid result=%h", dif.out.result);
          end else begin
            // accept edge follows the driving negedge; valid is seen LAT+1 negedges on
            check("latency", W'(cyc - sbq[0].acc), W'(LAT + 1));
          end
        end else begin
          check("result_hold", dif.out.result, prev_res);
        end
        if (dif.in.ready_out && sbq.size() > 0) begin
          t = sbq.pop_front();
          check($sformatf("result %h/%h", t.a, t.b), dif.out.result, t.exp);
        end
      end
      prev_v   <= dif.out.valid_out;
      prev_res <= dif.out.result;
    end else begin
      prev_v <= 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (!dif.out.ready_in && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!dif.out.ready_in) begin
      chk++;
      err++;
      $display("FAIL ready_in_timeout op=%h/%h", a, b);
      return;
    end
    dif.in.operand1 = a;
    dif.in.operand2 = b;
    dif.in.valid_in = 1'b1;
    sbq.push_back('{a: a, b: b, exp: exp, acc: cyc});
    @(negedge clk);
    check("ready_in_fall", W'(dif.out.ready_in), W'(0));
    // Operand churn and stray valids while busy must not disturb the result.
    for (int i = 0; i < M + 2; i++) begin
      dif.in.operand1 = W'($urandom);
      dif.in.operand2 = W'($urandom);
      dif.in.valid_in = 1'($urandom);
      @(negedge clk);
    end
    dif.in.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      chk++;
      err++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b;
    dif.in.operand1 = '0;
    dif.in.operand2 = '0;
    dif.in.valid_in = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_valid_out", W'(dif.out.valid_out), W'(0));
    check("rst_ready_in", W'(dif.out.ready_in), W'(0));
    check("rst_result", dif.out.result, W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", W'(dif.out.ready_in), W'(1));

    // Normal values
    issue(16'h3F80, 16'h3F80, 16'h3F80);
    issue(16'h3F80, 16'h4000, 16'h3F00);
    issue(16'h7F7F, 16'h7F7F, 16'h3F80);
    issue(16'h0080, 16'h3F80, 16'h0080);
    issue(16'h7F7F, 16'h3F80, 16'h7F7F);
    issue(16'hBF80, 16'h4000, 16'hBF00);
    issue(16'h3F80, 16'h4040, 16'h3EAB);
    // Zero / infinity
    issue(16'h3F80, 16'h0000, 16'h7F80);
    issue(16'h0000, 16'h3F80, 16'h0000);
    issue(16'h0000, 16'h0000, 16'h7FC0);
    issue(16'h7F80, 16'h7F80, 16'h7FC0);
    issue(16'h7F80, 16'h0000, 16'h7F80);
    issue(16'h0000, 16'h7F80, 16'h0000);
    issue(16'h3F80, 16'h7F80, 16'h0000);
    issue(16'h8000, 16'h3F80, 16'h8000);
    issue(16'hFF80, 16'h3F80, 16'hFF80);
    // NaN
    issue(16'h7FC0, 16'h3F80, 16'h7FC0);
    issue(16'h3F80, 16'h7FC0, 16'h7FC0);
    issue(16'h7FC0, 16'h7F80, 16'h7FC0);
    issue(16'h7F80, 16'h7FC0, 16'h7FC0);
    issue(16'h7FC0, 16'h0000, 16'h7FC0);
    issue(16'h0000, 16'h7FC0, 16'h7FC0);
    issue(16'h7FC0, 16'h7FC0, 16'h7FC0);
    issue(16'h7FBF, 16'h3F80, 16'h7FC0);
    issue(16'hFFC0, 16'h3F80, 16'h7FC0);
    // Flush / underflow / overflow
    issue(16'h0001, 16'h3F80, 16'h0000);
    issue(16'h007F, 16'h3F80, 16'h0000);
    issue(16'h0001, 16'h4000, 16'h0000);
    issue(16'h3F80, 16'h7F7F, 16'h0000);
    issue(16'h7F7F, 16'h0001, 16'h7F80);
    issue(16'hFF7F, 16'h0001, 16'hFF80);
    drain();

    // Backpressure
    bp_mode = 1'b1;
    bp_val  = 1'b0;
    issue(16'h4000, 16'h3F80, 16'h4000);
    n = 0;
    while (!dif.out.valid_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", W'(dif.out.valid_out), W'(1));
    dif.in.operand1 = 16'h3F80;
    dif.in.operand2 = 16'h3F80;
    dif.in.valid_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", W'(dif.out.valid_out), W'(1));
      check("bp_hold_result", dif.out.result, 16'h4000);
      check("bp_no_accept", W'(dif.out.ready_in), W'(0));
    end
    dif.in.valid_in = 1'b0;
    bp_val = 1'b1;
    @(negedge clk);
    check("bp_valid_until_ready", W'(dif.out.valid_out), W'(1));
    bp_val = 1'b0;
    @(negedge clk);
    check("bp_valid_drop", W'(dif.out.valid_out), W'(0));
    check("bp_ready_back", W'(dif.out.ready_in), W'(1));
    bp_mode = 1'b0;

    // Reset in the middle of an operation
    issue(16'h3F80, 16'h4000, 16'h3F00);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_out", W'(dif.out.valid_out), W'(0));
    check("midrst_ready_in", W'(dif.out.ready_in), W'(0));
    check("midrst_result", dif.out.result, W'(0));
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", W'(dif.out.ready_in), W'(1));

    // Randomised
    for (int i = 0; i < 300; i++) begin
      a = rnd_op();
      b = ($urandom_range(0, 3) == 0) ? {1'($urandom), E'(BIAS), M'(0)} : rnd_op();
      issue(a, b, ref_div(a, b));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #2000000;
    err++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
